mac_rx: RTL and testbench
=========================

# mac_rx

Receive-side MAC framer: accepts the byte stream produced by the MAC transmitter (valid/byte/last, final byte is the CRC byte), buffers the payload, checks the CRC byte, and replays good payloads to the downstream consumer over a valid/ready stream. It reports per-frame status (length, CRC error, length error) and counts frames dropped while busy. It sits between the PHY-side byte stream and the packet sink, one per link.

## Interface
- MAX_LEN, 256, maximum payload bytes stored per frame (CRC byte excluded)
- CRC_VAL, 8'h00, expected value of the trailing CRC byte
- LW, $clog2(MAX_LEN+1), width of length fields (derived, not overridden)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_valid  in  1  input byte valid; no backpressure, sampled every cycle
- rx_byte  in  8  input byte
- rx_last  in  1  marks the CRC byte (final byte of frame)
- out_valid  out  1  payload byte available
- out_byte  out  8  payload byte
- out_last  out  1  final payload byte of frame
- out_ready  in  1  downstream accepts byte when out_valid && out_ready
- status_valid  out  1  one-cycle pulse: frame finished
- status_len  out  LW  payload length of finished frame
- crc_err  out  1  qualified by status_valid: CRC byte != CRC_VAL
- len_err  out  1  qualified by status_valid: payload exceeded MAX_LEN
- busy  out  1  high in every state except IDLE
- drop_cnt  out  16  frames discarded because they arrived in DELIVER; saturates at 16'hFFFF

## Operation
- States: IDLE, RECV, DROP, DELIVER.
- IDLE: rx_valid && !rx_last -> store byte at addr 0, wptr=1, go RECV. rx_valid && rx_last -> zero-length frame: status pulse, status_len=0, crc_err per compare, no delivery, stay IDLE.
- RECV: rx_valid && !rx_last -> if wptr < MAX_LEN store at wptr, wptr++; else go DROP (byte discarded). rx_valid && rx_last -> compare rx_byte with CRC_VAL, latch len=wptr; CRC good -> DELIVER with rptr=0; CRC bad -> status pulse crc_err=1, status_len=wptr, IDLE. rx_valid low -> hold (gaps allowed).
- DROP: discard all bytes; on rx_valid && rx_last -> status pulse len_err=1, crc_err=0, status_len=MAX_LEN, IDLE. CRC not checked.
- DELIVER: out_valid=1, out_byte=buf[rptr], out_last=(rptr==len-1). Handshake advances rptr. Handshake with out_last -> status pulse crc_err=0 len_err=0 status_len=len, IDLE. Any rx_valid && rx_last seen in DELIVER -> drop_cnt++ (saturating); those bytes never stored.
- out_valid, once high, stays high and out_byte/out_last stable until handshake.
- crc_err and len_err never both 1.

## Timing
- Reset values: out_valid=0, out_last=0, status_valid=0, status_len=0, crc_err=0, len_err=0, busy=0, drop_cnt=0, state IDLE, wptr=rptr=0. out_byte value don't-care. Buffer contents not reset.
- All outputs from registered state; no combinational path input -> output.
- Good frame: out_valid rises the cycle after the CRC byte is sampled; with out_ready held high, N payload bytes leave in N consecutive cycles; status_valid pulses the cycle after the last handshake.
- Bad-CRC, zero-length, and DROP-terminated frames: status_valid pulses the cycle after rx_last sampled.
- Back-to-back: a frame starting the cycle after DELIVER exits is accepted normally; one starting during DELIVER is dropped whole, including bytes arriving after DELIVER exits until its rx_last (those go through DROP-like discard without a status pulse beyond the drop count).
- rst_n asserted mid-frame or mid-delivery: immediate return to reset values; partial frame lost, no status pulse.

## Structure
- Shared package mac_pkg: rx_state_t enum, CRC_FAKE = 8'h00 (also used by the transmitter), MAC_MAX_LEN = 256.
- Sub-module mac_rx_buf: MAX_LEN x 8 register buffer, one synchronous write port, one asynchronous read port addressed by registered rptr.
- Top holds FSM, pointers, CRC compare, status and drop counter.

## Test plan
- 4-byte frame 11 22 33 44 + CRC 00, out_ready=1 -> out bytes 11 22 33 44, out_last on 44, status_len=4, errors 0.
- Same frame with CRC 5A -> no out_valid, status_valid with crc_err=1, status_len=4.
- 257 payload bytes + CRC 00 (MAX_LEN=256) -> no delivery, len_err=1, status_len=256; next 1-byte frame delivered correctly.
- Good 3-byte frame, out_ready toggled 1,0,0,1,0,1 -> out_byte stable while stalled, 3 handshakes total, status pulse after third.
- Second frame sent during DELIVER stall -> drop_cnt=1, first frame delivered intact, second never appears.
- Reset asserted mid-RECV then 2-byte good frame -> outputs at reset values, new frame delivered, status_len=2.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared MAC definitions used by both the transmit and receive framers.
// No logic: types and constants only.
// Not applicable (no datapath).
package mac_pkg;

    // Receive framer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DROP    = 2'd2,
        DELIVER = 2'd3
    } rx_state_t;

    // Fixed CRC byte appended by the transmitter.
    localparam logic [7:0] CRC_FAKE    = 8'h00;
    localparam int         MAC_MAX_LEN = 256;

endpackage : mac_pkg

// File: rtl/mac_rx_buf.sv
// Payload store for one frame: DEPTH x 8 register file, one write port, one read port.
// Write lands on the clock edge; read data is combinational from the (registered) read address.
// No flow control; the owner decides when to write and which address to read.
module mac_rx_buf #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_dat_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_dat_o
);

    logic [7:0] mem_q [DEPTH];

    // Store one payload byte per enabled cycle; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
    end

    assign rd_dat_o = mem_q[rd_addr_i];

endmodule : mac_rx_buf

// File: rtl/mac_rx.sv
// Receive framer: buffers a frame, checks its trailing CRC byte, replays good payloads, reports status.
// out_valid rises the cycle after the CRC byte; status pulses one cycle after the frame resolves.
// Input side has no backpressure: frames arriving while a payload is being replayed are counted and discarded.
module mac_rx
    import mac_pkg::*;
#(
    parameter int         MAX_LEN = MAC_MAX_LEN,
    parameter logic [7:0] CRC_VAL = CRC_FAKE,
    localparam int        LW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_valid,
    input  logic [7:0]    rx_byte,
    input  logic          rx_last,
    output logic          out_valid,
    output logic [7:0]    out_byte,
    output logic          out_last,
    input  logic          out_ready,
    output logic          status_valid,
    output logic [LW-1:0] status_len,
    output logic          crc_err,
    output logic          len_err,
    output logic          busy,
    output logic [15:0]   drop_cnt
);

    localparam int            AW        = $clog2(MAX_LEN);
    localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

    rx_state_t     state_q;
    logic [LW-1:0] wptr_q;
    logic [LW-1:0] rptr_q;
    logic [LW-1:0] len_q;
    logic          out_valid_q;
    logic          out_last_q;
    logic          status_valid_q;
    logic [LW-1:0] status_len_q;
    logic          crc_err_q;
    logic          len_err_q;
    logic [15:0]   drop_cnt_q;
    logic [15:0]   drop_cnt_d;
    // Set while the tail of a frame that began during replay is still arriving.
    logic          skip_q;

    logic          crc_ok;
    logic          handshake;
    logic          drop_evt;
    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    logic [7:0]    buf_rdat;

    assign crc_ok    = (rx_byte == CRC_VAL);
    assign handshake = out_valid_q && out_ready;

    // A frame is counted as dropped when its final byte shows up during replay,
    // or when the final byte of a frame that started during replay arrives afterwards.
    assign drop_evt = rx_valid && rx_last &&
                      ((state_q == DELIVER) || ((state_q == IDLE) && skip_q));

    // Saturating drop counter next value.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_evt && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Payload bytes are written only while a frame is being accepted and fits in the buffer.
    always_comb begin
        buf_we    = 1'b0;
        buf_waddr = '0;
        if (rx_valid && !rx_last) begin
            if ((state_q == IDLE) && !skip_q) begin
                buf_we    = 1'b1;
                buf_waddr = '0;
            end else if ((state_q == RECV) && (wptr_q < MAX_LEN_L)) begin
                buf_we    = 1'b1;
                buf_waddr = wptr_q[AW-1:0];
            end
        end
    end

    mac_rx_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk       (clk),
        .wr_en_i   (buf_we),
        .wr_addr_i (buf_waddr),
        .wr_dat_i  (rx_byte),
        .rd_addr_i (rptr_q[AW-1:0]),
        .rd_dat_o  (buf_rdat)
    );

    // Framer FSM with registered stream and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            wptr_q         <= '0;
            rptr_q         <= '0;
            len_q          <= '0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            status_valid_q <= 1'b0;
            status_len_q   <= '0;
            crc_err_q      <= 1'b0;
            len_err_q      <= 1'b0;
            drop_cnt_q     <= '0;
            skip_q         <= 1'b0;
        end else begin
            status_valid_q <= 1'b0;
            drop_cnt_q     <= drop_cnt_d;
            case (state_q)
                IDLE: begin
                    if (skip_q) begin
                        if (rx_valid && rx_last) begin
                            skip_q <= 1'b0;
                        end
                    end else if (rx_valid) begin
                        if (rx_last) begin
                            // Zero-length frame: report only, nothing to replay.
                            status_valid_q <= 1'b1;
                            status_len_q   <= '0;
                            crc_err_q      <= !crc_ok;
                            len_err_q      <= 1'b0;
                        end else begin
                            wptr_q  <= LW'(1);
                            state_q <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (rx_valid) begin
                        if (!rx_last) begin
                            if (wptr_q < MAX_LEN_L) begin
                                wptr_q <= wptr_q + LW'(1);
                            end else begin
                                state_q <= DROP;
                            end
                        end else if (crc_ok) begin
                            len_q       <= wptr_q;
                            rptr_q      <= '0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= (wptr_q == LW'(1));
                            state_q     <= DELIVER;
                        end else begin
                            status_valid_q <= 1'b1;
                            status_len_q   <= wptr_q;
                            crc_err_q      <= 1'b1;
                            len_err_q      <= 1'b0;
                            state_q        <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (rx_valid && rx_last) begin
                        status_valid_q <= 1'b1;
                        status_len_q   <= MAX_LEN_L;
                        crc_err_q      <= 1'b0;
                        len_err_q      <= 1'b1;
                        state_q        <= IDLE;
                    end
                end
                DELIVER: begin
                    if (rx_valid) begin
                        skip_q <= !rx_last;
                    end
                    if (handshake) begin
                        if (out_last_q) begin
                            out_valid_q    <= 1'b0;
                            out_last_q     <= 1'b0;
                            rptr_q         <= '0;
                            status_valid_q <= 1'b1;
                            status_len_q   <= len_q;
                            crc_err_q      <= 1'b0;
                            len_err_q      <= 1'b0;
                            state_q        <= IDLE;
                        end else begin
                            rptr_q     <= rptr_q + LW'(1);
                            out_last_q <= ((rptr_q + LW'(2)) == len_q);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid    = out_valid_q;
    assign out_byte     = buf_rdat;
    assign out_last     = out_last_q;
    assign status_valid = status_valid_q;
    assign status_len   = status_len_q;
    assign crc_err      = crc_err_q;
    assign len_err      = len_err_q;
    assign busy         = (state_q != IDLE);
    assign drop_cnt     = drop_cnt_q;

endmodule : mac_rx

// File: tb/tb_mac_rx.sv
// Bench for the receive framer: directed scenarios plus randomized frames against a frame-level model.
// Inputs are driven 1ns after the rising edge; outputs are observed on the falling edge.
// out_ready is driven by the scenarios (held, patterned, or randomized per cycle).
module tb_mac_rx;

    localparam int MAX_LEN = 256;
    localparam int LW      = 9;

    typedef logic [7:0] bytes_t [$];
    typedef struct { logic [7:0] b; logic l; int c; } out_t;
    typedef struct { int len; logic ce; logic le; int c; } stat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic          rx_last;
    logic          out_valid;
    logic [7:0]    out_byte;
    logic          out_last;
    logic          out_ready;
    logic          status_valid;
    logic [LW-1:0] status_len;
    logic          crc_err;
    logic          len_err;
    logic          busy;
    logic [15:0]   drop_cnt;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    int    last_rx_cyc = 0;
    bit    rnd_rdy  = 1'b0;
    out_t  out_q[$];
    stat_t stat_q[$];

    always #5 clk = ~clk;

    mac_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .rx_last      (rx_last),
        .out_valid    (out_valid),
        .out_byte     (out_byte),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .status_valid (status_valid),
        .status_len   (status_len),
        .crc_err      (crc_err),
        .len_err      (len_err),
        .busy         (busy),
        .drop_cnt     (drop_cnt)
    );

    always @(posedge clk) cyc++;

    // Observer: records handshakes, status pulses and when the last CRC byte was presented.
    always @(negedge clk) begin
        if (out_valid && out_ready) out_q.push_back('{b: out_byte, l: out_last, c: cyc});
        if (status_valid) stat_q.push_back('{len: int'(status_len), ce: crc_err, le: len_err, c: cyc});
        if (rx_valid && rx_last) last_rx_cyc = cyc;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic l);
        tick();
        rx_valid = 1'b1;
        rx_byte  = b;
        rx_last  = l;
    endtask

    task automatic idle();
        tick();
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic send_frame(input bytes_t p, input logic [7:0] crc, input int gap_max);
        foreach (p[i]) begin
            int g;
            g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            for (int k = 0; k < g; k++) idle();
            drive_byte(p[i], 1'b0);
        end
        drive_byte(crc, 1'b1);
        idle();
    endtask

    task automatic wait_status(input string name, input int budget);
        int n;
        n = 0;
        while (stat_q.size() == 0 && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (stat_q.size() == 0) $display("FAIL %s: no status pulse within %0d cycles, required one", name, budget);
        else n_pass++;
    endtask

    task automatic clear_obs();
        out_q.delete();
        stat_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; rx_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        n_checks++;
        if ({out_valid, out_last, status_valid, crc_err, len_err, busy} !== 6'b0)
            $display("FAIL reset_flags: got %b required 000000", {out_valid, out_last, status_valid, crc_err, len_err, busy});
        else n_pass++;
        n_checks++;
        if (status_len !== '0) $display("FAIL reset_len: got %0d required 0", status_len); else n_pass++;
        n_checks++;
        if (drop_cnt !== 16'd0) $display("FAIL reset_drop: got %0d required 0", drop_cnt); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_good_frame();
        bytes_t p;
        bit bad;
        clear_obs();
        out_ready = 1'b1;
        p.push_back(8'h11); p.push_back(8'h22); p.push_back(8'h33); p.push_back(8'h44);
        send_frame(p, 8'h00, 0);
        wait_status("good_status", 50);
        n_checks++;
        if (out_q.size() != 4) $display("FAIL good_count: got %0d bytes required 4", out_q.size());
        else begin
            bad = 1'b0;
            foreach (p[i]) if (out_q[i].b !== p[i] || out_q[i].l !== (i == 3)) bad = 1'b1;
            if (bad) $display("FAIL good_bytes: got %h %h %h %h required 11 22 33 44 last on 44",
                              out_q[0].b, out_q[1].b, out_q[2].b, out_q[3].b);
            else n_pass++;
        end
        if (stat_q.size() > 0) begin
            n_checks++;
            if (stat_q[0].len != 4 || stat_q[0].ce !== 1'b0 || stat_q[0].le !== 1'b0)
                $display("FAIL good_stat: got len=%0d ce=%b le=%b required len=4 ce=0 le=0", stat_q[0].len, stat_q[0].ce, stat_q[0].le);
            else n_pass++;
        end
        if (out_q.size() == 4 && stat_q.size() > 0) begin
            n_checks++;
            bad = 1'b0;
            foreach (out_q[i]) if (out_q[i].c != last_rx_cyc + 1 + i) bad = 1'b1;
            if (bad || stat_q[0].c != last_rx_cyc + 5)
                $display("FAIL good_timing: first out at %0d status at %0d required %0d and %0d",
                         out_q[0].c, stat_q[0].c, last_rx_cyc + 1, last_rx_cyc + 5);
            else n_pass++;
        end
    endtask

    task automatic test_crc_err();
        bytes_t p;
        clear_obs();
        out_ready = 1'b1;
        p.push_back(8'h11); p.push_back(8'h22); p.push_back(8'h33); p.push_back(8'h44);
        send_frame(p, 8'h5A, 1);
        wait_status("crc_status", 50);
        tick(); tick();
        n_checks++;
        if (out_q.size() != 0) $display("FAIL crc_nodeliver: got %0d bytes required 0", out_q.size()); else n_pass++;
        if (stat_q.size() > 0) begin
            n_checks++;
            if (stat_q[0].len != 4 || stat_q[0].ce !== 1'b1 || stat_q[0].le !== 1'b0 || stat_q[0].c != last_rx_cyc + 1)
                $display("FAIL crc_stat: got len=%0d ce=%b le=%b at %0d required len=4 ce=1 le=0 at %0d",
                         stat_q[0].len, stat_q[0].ce, stat_q[0].le, stat_q[0].c, last_rx_cyc + 1);
            else n_pass++;
        end
    endtask

    task automatic test_len_err();
        bytes_t p;
        clear_obs();
        out_ready = 1'b1;
        for (int i = 0; i < MAX_LEN + 1; i++) p.push_back(8'($urandom));
        send_frame(p, 8'h00, 0);
        wait_status("len_status", 50);
        tick(); tick();
        n_checks++;
        if (out_q.size() != 0) $display("FAIL len_nodeliver: got %0d bytes required 0", out_q.size()); else n_pass++;
        if (stat_q.size() > 0) begin
            n_checks++;
            if (stat_q[0].len != MAX_LEN || stat_q[0].ce !== 1'b0 || stat_q[0].le !== 1'b1 || stat_q[0].c != last_rx_cyc + 1)
                $display("FAIL len_stat: got len=%0d ce=%b le=%b at %0d required len=256 ce=0 le=1 at %0d",
                         stat_q[0].len, stat_q[0].ce, stat_q[0].le, stat_q[0].c, last_rx_cyc + 1);
            else n_pass++;
        end
        clear_obs();
        p.delete();
        p.push_back(8'h77);
        send_frame(p, 8'h00, 0);
        wait_status("len_next_status", 50);
        n_checks++;
        if (out_q.size() != 1 || out_q[0].b !== 8'h77 || out_q[0].l !== 1'b1 || stat_q[0].len != 1)
            $display("FAIL len_next: got %0d bytes status_len=%0d required byte 77 last=1 status_len=1",
                     out_q.size(), (stat_q.size() > 0) ? stat_q[0].len : -1);
        else n_pass++;
    endtask

    task automatic test_stall();
        bytes_t p;
        logic [5:0] pat;
        logic [7:0] prev_b;
        logic prev_l, prev_r;
        clear_obs();
        out_ready = 1'b0;
        pat = 6'b101001;  // applied LSB first: 1,0,0,1,0,1
        p.push_back(8'hA1); p.push_back(8'hB2); p.push_back(8'hC3);
        send_frame(p, 8'h00, 0);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL stall_valid: got out_valid=%b required 1", out_valid); else n_pass++;
        prev_b = 8'h00; prev_l = 1'b0; prev_r = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            out_ready = pat[i];
            @(negedge clk);
            if (i > 0 && !prev_r) begin
                n_checks++;
                if ({out_valid, out_byte, out_last} !== {1'b1, prev_b, prev_l})
                    $display("FAIL stall_hold_%0d: got v=%b b=%h l=%b required v=1 b=%h l=%b",
                             i, out_valid, out_byte, out_last, prev_b, prev_l);
                else n_pass++;
            end
            prev_b = out_byte; prev_l = out_last; prev_r = pat[i];
        end
        tick();
        out_ready = 1'b0;
        wait_status("stall_status", 20);
        n_checks++;
        if (out_q.size() != 3 || out_q[0].b !== 8'hA1 || out_q[1].b !== 8'hB2 || out_q[2].b !== 8'hC3 || out_q[2].l !== 1'b1)
            $display("FAIL stall_bytes: got %0d handshakes required 3 (A1 B2 C3)", out_q.size());
        else n_pass++;
        if (out_q.size() == 3 && stat_q.size() > 0) begin
            n_checks++;
            if (stat_q[0].c != out_q[2].c + 1 || stat_q[0].len != 3)
                $display("FAIL stall_stat: got len=%0d at %0d required len=3 at %0d", stat_q[0].len, stat_q[0].c, out_q[2].c + 1);
            else n_pass++;
        end
    endtask

    task automatic test_drop_during_deliver();
        bytes_t p;
        clear_obs();
        out_ready = 1'b0;
        p.push_back(8'hD1); p.push_back(8'hD2); p.push_back(8'hD3);
        send_frame(p, 8'h00, 0);
        p.delete(); p.push_back(8'hE1); p.push_back(8'hE2);
        send_frame(p, 8'h00, 0);
        @(negedge clk);
        n_checks++;
        if (drop_cnt !== 16'd1) $display("FAIL drop_cnt: got %0d required 1", drop_cnt); else n_pass++;
        // A frame that starts during replay and finishes after it.
        drive_byte(8'hF1, 1'b0);
        drive_byte(8'hF2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle();
            out_ready = 1'b1;
        end
        drive_byte(8'hF3, 1'b0);
        drive_byte(8'h00, 1'b1);
        for (int i = 0; i < 4; i++) idle();
        n_checks++;
        if (out_q.size() != 3 || out_q[0].b !== 8'hD1 || out_q[1].b !== 8'hD2 || out_q[2].b !== 8'hD3)
            $display("FAIL drop_first: got %0d bytes required D1 D2 D3 only", out_q.size());
        else n_pass++;
        n_checks++;
        if (stat_q.size() != 1 || stat_q[0].len != 3 || stat_q[0].ce !== 1'b0 || stat_q[0].le !== 1'b0)
            $display("FAIL drop_stat: got %0d pulses required 1 with len=3 no errors", stat_q.size());
        else n_pass++;
        clear_obs();
        p.delete(); p.push_back(8'h5C);
        send_frame(p, 8'h00, 0);
        wait_status("drop_after_status", 20);
        n_checks++;
        if (out_q.size() != 1 || out_q[0].b !== 8'h5C || stat_q[0].len != 1)
            $display("FAIL drop_after: got %0d bytes required one byte 5C with status_len=1", out_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        bytes_t p;
        clear_obs();
        out_ready = 1'b1;
        drive_byte(8'h91, 1'b0);
        drive_byte(8'h92, 1'b0);
        drive_byte(8'h93, 1'b0);
        tick();
        rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_last, status_valid, crc_err, len_err, busy} !== 6'b0 || status_len !== '0)
            $display("FAIL rstmid_flags: got %b len=%0d required 000000 len=0",
                     {out_valid, out_last, status_valid, crc_err, len_err, busy}, status_len);
        else n_pass++;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (stat_q.size() != 0 || out_q.size() != 0)
            $display("FAIL rstmid_quiet: got %0d status %0d bytes required 0 and 0", stat_q.size(), out_q.size());
        else n_pass++;
        p.push_back(8'h3C); p.push_back(8'h4D);
        send_frame(p, 8'h00, 0);
        wait_status("rstmid_status", 20);
        n_checks++;
        if (out_q.size() != 2 || out_q[0].b !== 8'h3C || out_q[1].b !== 8'h4D || out_q[1].l !== 1'b1 || stat_q[0].len != 2)
            $display("FAIL rstmid_frame: got %0d bytes required 3C 4D with status_len=2", out_q.size());
        else n_pass++;
    endtask

    task automatic test_random();
        rnd_rdy = 1'b1;
        for (int f = 0; f < 40; f++) begin
            bytes_t p;
            int len, exp_len;
            logic [7:0] crc;
            logic exp_ce, exp_le;
            bit bad;
            len = ($urandom_range(0, 19) == 0) ? MAX_LEN + 1 + $urandom_range(0, 3) : $urandom_range(0, 12);
            crc = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            for (int i = 0; i < len; i++) p.push_back(8'($urandom));
            // Frame-level outcome from the framing rules.
            if (len > MAX_LEN) begin
                exp_len = MAX_LEN; exp_ce = 1'b0; exp_le = 1'b1;
            end else begin
                exp_len = len; exp_ce = (crc != 8'h00); exp_le = 1'b0;
            end
            clear_obs();
            send_frame(p, crc, 2);
            wait_status("rand_status", 200);
            if (stat_q.size() > 0) begin
                n_checks++;
                if (stat_q[0].len != exp_len || stat_q[0].ce !== exp_ce || stat_q[0].le !== exp_le)
                    $display("FAIL rand_stat_%0d: got len=%0d ce=%b le=%b required len=%0d ce=%b le=%b",
                             f, stat_q[0].len, stat_q[0].ce, stat_q[0].le, exp_len, exp_ce, exp_le);
                else n_pass++;
            end
            n_checks++;
            bad = 1'b0;
            if (exp_ce || exp_le || len == 0) begin
                if (out_q.size() != 0) bad = 1'b1;
            end else if (out_q.size() != len) begin
                bad = 1'b1;
            end else begin
                foreach (p[i]) if (out_q[i].b !== p[i] || out_q[i].l !== (i == len - 1)) bad = 1'b1;
            end
            if (bad) $display("FAIL rand_data_%0d: got %0d bytes for len=%0d crc=%h, payload or last flag differs",
                              f, out_q.size(), len, crc);
            else n_pass++;
        end
        rnd_rdy = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_good_frame();
        test_crc_err();
        test_len_err();
        test_stall();
        test_drop_during_deliver();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mac_rx
